// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types for the RV32I front end: the fetch packet that
//                travels into the instruction queue, the fetch FSM state
//                encoding, and small helpers used by the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

  // Packet written into the instruction queue; queue WIDTH = $bits(fetch_pkt_t).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [3:0]  C_RMASK_WORD = 4'b1111;
  localparam logic [31:0] C_INST_BYTES = 32'd4;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Front-end fetch stage. Owns the PC, issues one word read at a
//                time to instruction memory and enqueues {pc, inst} packets
//                into the instruction queue. Backend redirects flush the
//                queue and any in-flight response is discarded.
//  Ports       : clk, rst                - clock, synchronous active-high reset
//                imem_addr/imem_rmask    - memory request (rmask=1111 on issue)
//                imem_rdata/imem_resp    - memory response (one-cycle pulse)
//                iq_wdata/iq_enqueue     - packet and strobe to the queue
//                iq_is_full              - queue full flag (current cycle)
//                redirect_valid/_pc      - backend redirect
//                iq_flush                - queue flush, mirrors redirect_valid
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output fetch_pkt_t  iq_wdata,
  output logic        iq_enqueue,
  input  logic        iq_is_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        iq_flush
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         w_issue;
  logic         w_accept;
  logic         w_unused_ok;

  // Issue only from IDLE with queue space; a single outstanding request means
  // the queue can only drain before the response lands, so the enqueue in
  // WAIT always has room.
  always_comb begin
    w_issue  = !rst && (r_state == IDLE) && !redirect_valid && !iq_is_full;
    w_accept = !rst && (r_state == WAIT) && imem_resp && !redirect_valid;
  end

  assign imem_addr   = r_pc;
  assign imem_rmask  = w_issue ? C_RMASK_WORD : 4'b0000;
  assign iq_enqueue  = w_accept;
  assign iq_wdata    = '{pc: r_pc, inst: imem_rdata};
  assign iq_flush    = redirect_valid;
  assign w_unused_ok = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= align_word(RESET_PC);
      r_state <= IDLE;
    end else if (redirect_valid) begin
      r_pc <= align_word(redirect_pc);
      // A response arriving with the redirect is consumed here; otherwise the
      // outstanding one must still be swallowed in DROP. This also covers a
      // redirect in DROP coinciding with the stale response, which would
      // otherwise leave DROP waiting for a response that never comes.
      if (r_state == IDLE) begin
        r_state <= IDLE;
      end else begin
        r_state <= imem_resp ? IDLE : DROP;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            r_pc    <= r_pc + C_INST_BYTES;
            r_state <= IDLE;
          end
        end
        DROP: begin
          if (imem_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!((r_state == IDLE) && imem_resp));
      assert (!(iq_enqueue && iq_is_full));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Inputs change on
//                the falling edge, outputs are sampled 1 ns later, and state
//                advances on the following rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [63:0] iq_wdata;
  logic        iq_enqueue;
  logic        iq_is_full;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iq_flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h6000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .iq_wdata       (iq_wdata),
    .iq_enqueue     (iq_enqueue),
    .iq_is_full     (iq_is_full),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .iq_flush       (iq_flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle: through the rising edge to the next falling edge,
  // then settle 1 ns so combinational outputs reflect the new inputs.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  // Expect an issue at addr in this cycle.
  task automatic chk_issue(input string tag, input logic [31:0] addr);
    chk({tag, "_rmask"}, {60'd0, imem_rmask}, 64'hF);
    chk({tag, "_addr"}, {32'd0, imem_addr}, {32'd0, addr});
    chk({tag, "_enq"}, {63'd0, iq_enqueue}, 64'd0);
  endtask

  // Expect an enqueue of {pc, inst} in this cycle.
  task automatic chk_enq(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_enq"}, {63'd0, iq_enqueue}, 64'd1);
    chk({tag, "_wdata"}, iq_wdata, {pc, inst});
    chk({tag, "_rmask"}, {60'd0, imem_rmask}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; imem_rdata = '0; imem_resp = 1'b0; iq_is_full = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Reset: no request and no enqueue while rst is held.
    next_cycle(); settle();
    chk("rst_rmask", {60'd0, imem_rmask}, 64'd0);
    chk("rst_enq", {63'd0, iq_enqueue}, 64'd0);
    next_cycle();
    rst = 1'b0; settle();

    // Back-to-back fetches with 1-cycle memory: issue, enqueue, issue, ...
    chk_issue("f0", 32'h6000_0000);
    next_cycle(); imem_resp = 1'b1; imem_rdata = 32'h1111_1111; settle();
    chk_enq("e0", 32'h6000_0000, 32'h1111_1111);
    next_cycle(); imem_resp = 1'b0; settle();
    chk_issue("f1", 32'h6000_0004);
    next_cycle(); imem_resp = 1'b1; imem_rdata = 32'h2222_2222; settle();
    chk_enq("e1", 32'h6000_0004, 32'h2222_2222);
    next_cycle(); imem_resp = 1'b0; settle();
    chk_issue("f2", 32'h6000_0008);
    next_cycle(); imem_resp = 1'b1; imem_rdata = 32'h3333_3333; settle();
    chk_enq("e2", 32'h6000_0008, 32'h3333_3333);

    // Queue full for 5 cycles in IDLE: no request at all.
    next_cycle(); imem_resp = 1'b0; iq_is_full = 1'b1; settle();
    for (int i = 0; i < 5; i++) begin
      chk("full_rmask", {60'd0, imem_rmask}, 64'd0);
      if (i < 4) begin
        next_cycle(); settle();
      end
    end
    next_cycle(); iq_is_full = 1'b0; settle();
    chk_issue("f3", 32'h6000_000C);

    // Redirect while in WAIT; stale response arrives 3 cycles later.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h6000_1003; settle();
    chk("rd_flush", {63'd0, iq_flush}, 64'd1);
    chk("rd_enq", {63'd0, iq_enqueue}, 64'd0);
    next_cycle(); redirect_valid = 1'b0; settle();
    chk("drop_flush", {63'd0, iq_flush}, 64'd0);
    chk("drop_rmask1", {60'd0, imem_rmask}, 64'd0);
    chk("drop_addr", {32'd0, imem_addr}, 64'h6000_1000);
    next_cycle(); settle();
    chk("drop_rmask2", {60'd0, imem_rmask}, 64'd0);
    next_cycle(); imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
    chk("drop_enq", {63'd0, iq_enqueue}, 64'd0);
    next_cycle(); imem_resp = 1'b0; settle();
    chk_issue("f4", 32'h6000_1000);

    // Redirect coinciding with the response: response dropped, no +4.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h6000_2008;
    imem_resp = 1'b1; imem_rdata = 32'hBAD0_BAD0; settle();
    chk("rdr_enq", {63'd0, iq_enqueue}, 64'd0);
    chk("rdr_flush", {63'd0, iq_flush}, 64'd1);
    next_cycle(); redirect_valid = 1'b0; imem_resp = 1'b0; settle();
    chk_issue("f5", 32'h6000_2008);
    next_cycle(); imem_resp = 1'b1; imem_rdata = 32'h4444_4444; settle();
    chk_enq("e5", 32'h6000_2008, 32'h4444_4444);

    // Redirect in IDLE to the top word, then wrap to zero.
    next_cycle(); imem_resp = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; settle();
    chk("ri_rmask", {60'd0, imem_rmask}, 64'd0);
    next_cycle(); redirect_valid = 1'b0; settle();
    chk_issue("f6", 32'hFFFF_FFFC);
    next_cycle(); imem_resp = 1'b1; imem_rdata = 32'h5555_5555; settle();
    chk_enq("e6", 32'hFFFF_FFFC, 32'h5555_5555);
    next_cycle(); imem_resp = 1'b0; settle();
    chk_issue("f7", 32'h0000_0000);

    // Reset while in WAIT: no enqueue, then fetch restarts at RESET_PC.
    next_cycle(); rst = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h6666_6666; settle();
    chk("rstw_enq", {63'd0, iq_enqueue}, 64'd0);
    chk("rstw_rmask", {60'd0, imem_rmask}, 64'd0);
    next_cycle(); rst = 1'b0; imem_resp = 1'b0; settle();
    chk_issue("f8", 32'h6000_0000);
    next_cycle(); imem_resp = 1'b1; imem_rdata = 32'h7777_7777; settle();
    chk_enq("e8", 32'h6000_0000, 32'h7777_7777);
    next_cycle(); imem_resp = 1'b0; settle();
    chk_issue("f9", 32'h6000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
